// File: rtl/counter_ring_sequencer_if.sv
// Control/status and dual-rail ring signals between a sequencer and its environment.
// The slave modport is the sequencer side; master is the driver/ring side.
interface counter_ring_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] step_count;
  logic             ring_init;
  logic [1:0]       carry_drive;
  logic             sum_ack;
  logic [1:0]       sum_obs;
  logic [1:0]       carry_obs;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] steps_done;
  logic [CNT_W-1:0] carry_count;

  modport master (
    output start, step_count, sum_obs, carry_obs,
    input  ring_init, carry_drive, sum_ack, busy, done, err, err_code,
           steps_done, carry_count
  );

  modport slave (
    input  start, step_count, sum_obs, carry_obs,
    output ring_init, carry_drive, sum_ack, busy, done, err, err_code,
           steps_done, carry_count
  );
endinterface

// File: rtl/counter_ring_sequencer.sv
// Sequences DATA/NULL waves into an NCL increment ring, counting completed waves and carries.
// Ring observations are resynchronised; a watchdog and a dual-rail legality check end a run in ERR.
module counter_ring_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_init,
  counter_ring_sequencer_if.slave  bus
);

  localparam int               WD_W    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RINIT,
    S_REQ_DATA,
    S_WAIT_NULL,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_sum_meta;
  logic [1:0]       r_sum_sync;
  logic [1:0]       r_carry_meta;
  logic [1:0]       r_carry_sync;
  logic [CNT_W-1:0] r_step_target;
  logic [CNT_W-1:0] r_steps_done;
  logic [CNT_W-1:0] r_carry_count;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [1:0]       r_rinit_cnt;
  logic [WD_W-1:0]  r_wd;

  logic             w_accept;
  logic             w_step_inc;
  logic             w_carry_inc;
  logic             w_err_set;
  logic [1:0]       w_err_code_nxt;
  logic             w_both_data;
  logic             w_both_null;
  logic             w_illegal;
  logic             w_wd_expired;
  logic             w_wait_state;
  logic [CNT_W-1:0] w_steps_next;

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_sum_meta   <= 2'b00;
      r_sum_sync   <= 2'b00;
      r_carry_meta <= 2'b00;
      r_carry_sync <= 2'b00;
    end else begin
      r_sum_meta   <= bus.sum_obs;
      r_sum_sync   <= r_sum_meta;
      r_carry_meta <= bus.carry_obs;
      r_carry_sync <= r_carry_meta;
    end
  end

  // Complete DATA means exactly one rail high on each pair.
  assign w_both_data  = (^r_sum_sync) && (^r_carry_sync);
  assign w_both_null  = (r_sum_sync == 2'b00) && (r_carry_sync == 2'b00);
  assign w_illegal    = (&r_sum_sync) || (&r_carry_sync);
  assign w_wait_state = (r_state == S_REQ_DATA) || (r_state == S_WAIT_NULL);
  assign w_wd_expired = w_wait_state && (r_wd == WD_LAST);
  assign w_steps_next = (r_steps_done == CNT_MAX) ? r_steps_done : r_steps_done + 1'b1;

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_step_inc     = 1'b0;
    w_carry_inc    = 1'b0;
    w_err_set      = 1'b0;
    w_err_code_nxt = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RINIT;
        end
      end
      S_RINIT: begin
        if (r_rinit_cnt == 2'd3) begin
          w_next = (r_step_target == '0) ? S_DONE : S_REQ_DATA;
        end
      end
      S_REQ_DATA: begin
        if (w_illegal) begin
          w_next         = S_ERR;
          w_err_set      = 1'b1;
          w_err_code_nxt = 2'b10;
        end else if (w_both_data) begin
          w_carry_inc = (r_carry_sync == 2'b10);
          w_next      = S_WAIT_NULL;
        end else if (w_wd_expired) begin
          w_next         = S_ERR;
          w_err_set      = 1'b1;
          w_err_code_nxt = 2'b01;
        end
      end
      S_WAIT_NULL: begin
        if (w_illegal) begin
          w_next         = S_ERR;
          w_err_set      = 1'b1;
          w_err_code_nxt = 2'b10;
        end else if (w_both_null) begin
          w_step_inc = 1'b1;
          w_next     = (w_steps_next == r_step_target) ? S_DONE : S_REQ_DATA;
        end else if (w_wd_expired) begin
          w_next         = S_ERR;
          w_err_set      = 1'b1;
          w_err_code_nxt = 2'b01;
        end
      end
      S_DONE: begin
        if (w_illegal) begin
          w_next         = S_ERR;
          w_err_set      = 1'b1;
          w_err_code_nxt = 2'b10;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ERR: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RINIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_state       <= S_IDLE;
      r_step_target <= '0;
      r_steps_done  <= '0;
      r_carry_count <= '0;
      r_err         <= 1'b0;
      r_err_code    <= 2'b00;
      r_rinit_cnt   <= 2'd0;
      r_wd          <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_step_target <= bus.step_count;
        r_steps_done  <= '0;
        r_carry_count <= '0;
        r_err         <= 1'b0;
        r_err_code    <= 2'b00;
      end
      if (w_step_inc) begin
        r_steps_done <= w_steps_next;
      end
      if (w_carry_inc && (r_carry_count != CNT_MAX)) begin
        r_carry_count <= r_carry_count + 1'b1;
      end
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code_nxt;
      end
      r_rinit_cnt <= (r_state == S_RINIT) ? r_rinit_cnt + 2'd1 : 2'd0;
      // Watchdog restarts on every state entry and only runs while waiting on the ring.
      if (w_next != r_state) begin
        r_wd <= '0;
      end else if (w_wait_state) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign bus.ring_init   = i_init || (r_state == S_RINIT);
  assign bus.carry_drive = (r_state == S_REQ_DATA) ? 2'b10 : 2'b00;
  assign bus.sum_ack     = (r_state != S_REQ_DATA);
  assign bus.busy        = (r_state == S_RINIT) || w_wait_state;
  assign bus.done        = (r_state == S_DONE);
  assign bus.err         = r_err;
  assign bus.err_code    = r_err_code;
  assign bus.steps_done  = r_steps_done;
  assign bus.carry_count = r_carry_count;

endmodule

// File: tb/tb_counter_ring_sequencer.sv
// Drives directed runs against a behavioural one-bit NCL increment ring; a monitor
// checks each done/err event against a queue of expected outcomes.
module tb_counter_ring_sequencer;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;

  typedef struct {
    int         kind;     // 0 = done pulse, 1 = error entry
    int         steps;
    int         carries;
    logic [1:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic init;
  logic stuck;
  logic inject_wn;
  logic ring_v;

  int checks = 0;
  int errors = 0;
  int events_seen = 0;
  int rinit_cycles = 0;
  int data_cycles = 0;
  int data_entries = 0;
  int done_pulses = 0;
  logic [1:0] prev_cd = 2'b00;
  logic       prev_err = 1'b0;
  exp_t exp_q[$];

  counter_ring_sequencer_if #(.CNT_W(CNT_W)) bus ();

  counter_ring_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (clk),
    .i_init (init),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_evt(input int kind, input int steps, input int carries, input logic [1:0] code);
    exp_t e;
    e.kind = kind; e.steps = steps; e.carries = carries; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic clear_tallies();
    rinit_cycles = 0; data_cycles = 0; data_entries = 0; done_pulses = 0;
  endtask

  task automatic do_start(input int n);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.step_count = CNT_W'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_events(input int target, input int budget);
    int n = 0;
    while (events_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (events_seen < target) begin
      errors++;
      $display("FAIL wait_event: got %0d events expected %0d within %0d cycles", events_seen, target, budget);
    end
  endtask

  // Ring: each DATA wave adds carry-in 1 to a one-bit value; DATA1 = 10, DATA0 = 01.
  always @(negedge clk) begin
    if (bus.ring_init) begin
      ring_v = 1'b0;
      bus.sum_obs = 2'b00;
      bus.carry_obs = 2'b00;
    end else if (stuck) begin
      bus.sum_obs = 2'b00;
      bus.carry_obs = 2'b00;
    end else if (bus.carry_drive == 2'b10 && !bus.sum_ack) begin
      if (bus.sum_obs == 2'b00) begin
        bus.sum_obs   = ring_v ? 2'b01 : 2'b10;
        bus.carry_obs = ring_v ? 2'b10 : 2'b01;
        ring_v = ~ring_v;
      end
    end else if (bus.carry_drive == 2'b00 && bus.sum_ack) begin
      if (inject_wn && bus.busy) bus.sum_obs = 2'b11;
      else begin
        bus.sum_obs = 2'b00;
        bus.carry_obs = 2'b00;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.ring_init && !init) rinit_cycles++;
    if (bus.carry_drive == 2'b10) data_cycles++;
    if (bus.carry_drive == 2'b10 && prev_cd != 2'b10) data_entries++;
    if (bus.done === 1'b1) done_pulses++;
    if (bus.done === 1'b1 || (bus.err === 1'b1 && prev_err === 1'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got done=%0b err=%0b expected none", bus.done, bus.err);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", bus.done ? 0 : 1, e.kind);
        chk("evt_steps_done", bus.steps_done, e.steps);
        chk("evt_carry_count", bus.carry_count, e.carries);
        if (e.kind == 1) begin
          chk("evt_err_code", bus.err_code, e.code);
          chk("evt_err_carry_drive", bus.carry_drive, 2'b00);
          chk("evt_err_busy", bus.busy, 1'b0);
        end
      end
      events_seen++;
    end
    prev_cd = bus.carry_drive;
    prev_err = bus.err;
  end

  initial begin
    init = 1'b1; stuck = 1'b0; inject_wn = 1'b0; ring_v = 1'b0;
    bus.start = 1'b0; bus.step_count = '0;
    bus.sum_obs = 2'b00; bus.carry_obs = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ring_init", bus.ring_init, 1'b1);
    chk("rst_carry_drive", bus.carry_drive, 2'b00);
    chk("rst_sum_ack", bus.sum_ack, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_err_code", bus.err_code, 2'b00);
    chk("rst_steps_done", bus.steps_done, 0);
    chk("rst_carry_count", bus.carry_count, 0);
    @(posedge clk); #1 init = 1'b0;
    @(negedge clk);
    chk("idle_ring_init", bus.ring_init, 1'b0);

    // Four waves from 0: sums 1,0,1,0 -> carries on waves 2 and 4.
    clear_tallies();
    expect_evt(0, 4, 2, 2'b00);
    do_start(4);
    wait_events(1, 200);
    chk("a_rinit_cycles", rinit_cycles, 4);
    chk("a_data_waves", data_entries, 4);
    chk("a_done_pulses", done_pulses, 1);
    @(negedge clk);
    chk("a_idle_busy", bus.busy, 1'b0);
    chk("a_steps_held", bus.steps_done, 4);

    // Zero steps: RINIT straight to DONE, never drives DATA.
    clear_tallies();
    expect_evt(0, 0, 0, 2'b00);
    do_start(0);
    wait_events(2, 50);
    chk("b_rinit_cycles", rinit_cycles, 4);
    chk("b_data_waves", data_entries, 0);
    chk("b_done_pulses", done_pulses, 1);

    // Stuck ring: REQ_DATA held for exactly TIMEOUT cycles, then timeout error.
    clear_tallies();
    stuck = 1'b1;
    expect_evt(1, 0, 0, 2'b01);
    do_start(3);
    wait_events(3, TIMEOUT + 50);
    chk("c_req_data_cycles", data_cycles, TIMEOUT);
    repeat (5) @(negedge clk);
    chk("c_err_sticky", bus.err, 1'b1);
    chk("c_err_code", bus.err_code, 2'b01);
    chk("c_carry_drive", bus.carry_drive, 2'b00);
    stuck = 1'b0;

    // Illegal 11 on sum during first WAIT_NULL; start from ERR clears the error.
    inject_wn = 1'b1;
    expect_evt(1, 0, 0, 2'b10);
    do_start(4);
    @(negedge clk);
    chk("d_err_cleared", bus.err, 1'b0);
    chk("d_code_cleared", bus.err_code, 2'b00);
    chk("d_busy", bus.busy, 1'b1);
    wait_events(4, 100);
    inject_wn = 1'b0;
    expect_evt(0, 2, 1, 2'b00);
    do_start(2);
    wait_events(5, 100);
    chk("d_err_after_rerun", bus.err, 1'b0);

    // Start while busy is ignored: run of 3 completes with one carry.
    clear_tallies();
    expect_evt(0, 3, 1, 2'b00);
    do_start(3);
    repeat (6) @(posedge clk);
    chk("e_busy_at_pulse1", bus.busy, 1'b1);
    do_start(1);
    repeat (4) @(posedge clk);
    chk("e_busy_at_pulse2", bus.busy, 1'b1);
    do_start(7);
    wait_events(6, 200);
    chk("e_data_waves", data_entries, 3);
    chk("e_done_pulses", done_pulses, 1);

    // init during wave 3 of 8 aborts without a done pulse.
    clear_tallies();
    do_start(8);
    for (int i = 0; i < 300 && data_entries < 3; i++) @(negedge clk);
    chk("f_reached_wave3", data_entries >= 3, 1'b1);
    @(posedge clk); #1 init = 1'b1;
    @(negedge clk);
    chk("f_ring_init_held", bus.ring_init, 1'b1);
    @(posedge clk); #1 init = 1'b0;
    @(negedge clk);
    chk("f_ring_init", bus.ring_init, 1'b0);
    chk("f_busy", bus.busy, 1'b0);
    chk("f_done", bus.done, 1'b0);
    chk("f_err", bus.err, 1'b0);
    chk("f_carry_drive", bus.carry_drive, 2'b00);
    chk("f_sum_ack", bus.sum_ack, 1'b1);
    chk("f_steps_done", bus.steps_done, 0);
    chk("f_carry_count", bus.carry_count, 0);
    repeat (20) @(negedge clk);
    chk("f_no_done", done_pulses, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ring_sequencer.md
COUNTER_RING_SEQUENCER -- requirements
Module: counter_ring_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of step_count, steps_done and carry_count.
REQ-002 Parameter TIMEOUT, default 255: maximum clk cycles spent in one wait state before an error is declared.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 init  input  1  synchronous reset, active-high.
REQ-005 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 step_count  input  CNT_W  number of increment waves to run; captured when start is accepted.
REQ-007 ring_init  output  1  init drive to the NCL ring.
REQ-008 carry_drive  output  2  dual-rail carryin to the ring: 00 NULL, 10 DATA1 (rail1 = TRUE), 01 DATA0.
REQ-009 sum_ack  output  2->1  width 1  sumcomp to the ring: 1 = request-for-NULL, 0 = request-for-DATA.
REQ-010 sum_obs  input  2  ring sumout, asynchronous to clk.
REQ-011 carry_obs  input  2  ring carryout, asynchronous to clk.
REQ-012 busy  output  1  run in progress (RINIT through WAIT_NULL).
REQ-013 done  output  1  one-cycle pulse on successful run completion.
REQ-014 err  output  1  sticky error; cleared only by init or by the next accepted start.
REQ-015 err_code  output  2  00 none, 01 timeout, 10 illegal dual-rail (11 on a pair), 11 reserved.
REQ-016 steps_done  output  CNT_W  completed waves in the current or last run.
REQ-017 carry_count  output  CNT_W  waves whose captured carry_obs was DATA1.

Function
REQ-018 sum_obs and carry_obs SHALL each pass through a 2-flop synchronizer; all decisions use the synchronized values (sS, sC).
REQ-019 FSM states: IDLE, RINIT, REQ_DATA, WAIT_NULL, DONE, ERR.
REQ-020 IDLE: carry_drive=00, sum_ack=1, ring_init=0; start=1 -> capture step_count, clear steps_done, carry_count, err and err_code -> RINIT.
REQ-021 RINIT: ring_init=1, carry_drive=00, sum_ack=1 for exactly 4 cycles -> REQ_DATA; if the captured step_count=0, go from RINIT to DONE instead.
REQ-022 REQ_DATA: carry_drive=10, sum_ack=0; when sS and sC are both complete DATA (exactly one rail high each), in that same cycle increment carry_count if sC=10 -> WAIT_NULL.
REQ-023 WAIT_NULL: carry_drive=00, sum_ack=1; when sS=00 and sC=00, increment steps_done; if the new steps_done equals the captured step_count -> DONE, else -> REQ_DATA.
REQ-024 DONE: done=1 for one cycle, carry_drive=00, sum_ack=1 -> IDLE.
REQ-025 Watchdog: an 8-bit-min counter clears on every state entry and counts in REQ_DATA and WAIT_NULL; reaching TIMEOUT -> ERR with err_code=01.
REQ-026 sS=11 or sC=11 in any state except IDLE and RINIT -> ERR with err_code=10; this takes priority over the timeout.
REQ-027 ERR: err=1, carry_drive=00, sum_ack=1, busy=0; start=1 -> behaves as the IDLE start transition.
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 start asserted while busy SHALL be ignored, with no change to the captured step_count.
REQ-030 carry_drive SHALL never change DATA->DATA directly; NULL SHALL separate successive DATA waves.

Reset
REQ-031 init=1 on a clk edge -> state IDLE, ring_init=1 while init is held, carry_drive=00, sum_ack=1, busy=0, done=0, err=0, err_code=00, steps_done=0, carry_count=0, synchronizers=00, watchdog=0.
REQ-032 init asserted mid-run SHALL abort the run with no done pulse; the first cycle after release is IDLE with ring_init=0.

Verification
REQ-033 Behavioural ring model, step_count=4, ring starting at 0 -> steps_done=4, carry_count=2 (carries on the 1->0 sum transitions), one done pulse, DONE reached after RINIT.
REQ-034 step_count=0, start -> 4 ring_init cycles, then done pulse, steps_done=0, carry_drive never leaves 00.
REQ-035 Ring model stuck (sum_obs held 00) -> after TIMEOUT cycles in REQ_DATA: err=1, err_code=01, carry_drive=00.
REQ-036 sum_obs=11 injected during WAIT_NULL -> ERR after the synchronizer delay, err_code=10; a subsequent start clears err and the run proceeds normally.
REQ-037 init pulsed during wave 3 of 8 -> next cycle IDLE, all outputs at reset values, no done; start pulsed during a run -> ignored.
